// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register read/write request into the full i2c_master
// command sequence (strobed commands, busy polling, error/timeout recovery)
// and returns a single response pulse.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_rnw, req_dev, req_reg,       request fields (read/write, 7-bit device,
//   req_wdat                         register index, write data)
//   rsp_valid, rsp_rdat,             one-cycle response with read data and
//   rsp_err, rsp_tmo                 error / timeout flags
//   mst_cmd, mst_dat, mst_ws         command, data and write strobe to master
//   mst_stat, mst_rdat               master status {ERR,BSY} and read data
module i2c_reg_seq #(
  parameter int unsigned TMO_CYC = 1000000,
  parameter int unsigned TMO_W   = 20,
  localparam int unsigned C_SZ   = 6,
  localparam int unsigned S_SZ   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_rnw,
  input  logic [6:0]      req_dev,
  input  logic [7:0]      req_reg,
  input  logic [7:0]      req_wdat,
  output logic            rsp_valid,
  output logic [7:0]      rsp_rdat,
  output logic            rsp_err,
  output logic            rsp_tmo,
  output logic [C_SZ-1:0] mst_cmd,
  output logic [7:0]      mst_dat,
  output logic            mst_ws,
  input  logic [S_SZ-1:0] mst_stat,
  input  logic [7:0]      mst_rdat
);

  // Master command bits and status bit positions
  localparam logic [C_SZ-1:0] C_STRT = 6'b000001;
  localparam logic [C_SZ-1:0] C_STOP = 6'b000010;
  localparam logic [C_SZ-1:0] C_READ = 6'b000100;
  localparam logic [C_SZ-1:0] C_WRTE = 6'b001000;
  localparam logic [C_SZ-1:0] C_NACK = 6'b010000;
  localparam logic [C_SZ-1:0] C_CLRS = 6'b100000;
  localparam int unsigned SB_BSY = 0;
  localparam int unsigned SB_ERR = 1;

  typedef enum logic [3:0] {
    IDLE, ADDRW, REG, WDATA, ADDRR, RDATA, STOP, CLR, ABORTSTOP, RESP
  } state_t;

  typedef enum logic [1:0] {ISSUE, SETTLE, POLL} sub_t;

  state_t           state, state_n;
  sub_t             sub, sub_n;
  logic [TMO_W-1:0] tmo_cnt, cnt_n;
  logic [7:0]       rdat_q, rdat_n;
  logic             rnw_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q, wdat_q;
  logic             accept, fail, tmo_hit;
  logic             ws_n;
  logic [C_SZ-1:0]  cmd_n;
  logic [7:0]       dat_n;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sub       <= ISSUE;
      tmo_cnt   <= '0;
      rdat_q    <= '0;
      rnw_q     <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdat_q    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdat  <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      mst_cmd   <= '0;
      mst_dat   <= '0;
      mst_ws    <= 1'b0;
    end else begin
      state     <= state_n;
      sub       <= sub_n;
      tmo_cnt   <= cnt_n;
      rdat_q    <= rdat_n;
      req_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      mst_ws    <= ws_n;
      mst_cmd   <= cmd_n;
      mst_dat   <= dat_n;
      if (accept) begin
        rnw_q    <= req_rnw;
        dev_q    <= req_dev;
        reg_q    <= req_reg;
        wdat_q   <= req_wdat;
        rsp_err  <= 1'b0;
        rsp_tmo  <= 1'b0;
        rsp_rdat <= '0;
      end
      // Response fields are fixed on entry to RESP and held until next accept
      if (state_n == RESP) begin
        rsp_err  <= fail;
        rsp_tmo  <= tmo_hit;
        rsp_rdat <= (fail || !rnw_q) ? 8'h00 : rdat_n;
      end
    end
  end

  // Next state, step sequencing and next master command
  always_comb begin
    state_n = state;
    sub_n   = sub;
    cnt_n   = tmo_cnt;
    rdat_n  = rdat_q;
    accept  = 1'b0;
    fail    = 1'b0;
    tmo_hit = 1'b0;
    ws_n    = 1'b0;
    cmd_n   = mst_cmd;
    dat_n   = mst_dat;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_n = ADDRW;
          sub_n   = ISSUE;
        end
      end
      RESP: state_n = IDLE;
      default: begin
        case (sub)
          ISSUE: begin
            sub_n = SETTLE;
            cnt_n = '0;
          end
          SETTLE: begin
            // CLR is fire-and-forget: no busy poll before the abort STOP
            if (state == CLR) begin
              state_n = ABORTSTOP;
              sub_n   = ISSUE;
            end else begin
              sub_n = POLL;
            end
          end
          default: begin
            if (mst_stat[SB_BSY]) begin
              if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                state_n = RESP;
                fail    = 1'b1;
                tmo_hit = 1'b1;
              end else begin
                cnt_n = tmo_cnt + TMO_W'(1);
              end
            end else if (state == ABORTSTOP) begin
              // Error from the abort STOP itself is ignored
              state_n = RESP;
              fail    = 1'b1;
            end else if (mst_stat[SB_ERR]) begin
              state_n = CLR;
              sub_n   = ISSUE;
            end else begin
              sub_n = ISSUE;
              case (state)
                ADDRW:   state_n = REG;
                REG:     state_n = rnw_q ? ADDRR : WDATA;
                ADDRR:   state_n = RDATA;
                RDATA: begin
                  state_n = STOP;
                  rdat_n  = mst_rdat;
                end
                default: state_n = RESP;
              endcase
            end
          end
        endcase
      end
    endcase

    // Command/data change only on a strobe; cleared when back in IDLE
    if (state_n == IDLE) begin
      cmd_n = '0;
      dat_n = '0;
    end else if (sub_n == ISSUE && state_n != RESP) begin
      ws_n = 1'b1;
      case (state_n)
        ADDRW: begin
          cmd_n = C_STRT | C_WRTE;
          dat_n = {req_dev, 1'b0};
        end
        REG: begin
          cmd_n = C_WRTE;
          dat_n = reg_q;
        end
        WDATA: begin
          cmd_n = C_WRTE | C_STOP;
          dat_n = wdat_q;
        end
        ADDRR: begin
          cmd_n = C_STRT | C_WRTE;
          dat_n = {dev_q, 1'b1};
        end
        RDATA: begin
          cmd_n = C_READ | C_NACK;
          dat_n = 8'h00;
        end
        CLR: begin
          cmd_n = C_CLRS;
          dat_n = 8'h00;
        end
        default: begin
          cmd_n = C_STOP;
          dat_n = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: drives i2c_reg_seq against a behavioural stub master with a
// register RAM device, checking command streams and responses against a
// request-level reference model.
module tb_i2c_reg_seq;

  localparam logic [5:0] C_STRT = 6'h01;
  localparam logic [5:0] C_STOP = 6'h02;
  localparam logic [5:0] C_READ = 6'h04;
  localparam logic [5:0] C_WRTE = 6'h08;
  localparam logic [5:0] C_NACK = 6'h10;
  localparam logic [5:0] C_CLRS = 6'h20;
  localparam logic [6:0] DEV    = 7'h3A;
  localparam int         TMO    = 50;

  typedef struct packed {
    logic [5:0] cmd;
    logic [7:0] dat;
    logic       care;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdat;
  logic       rsp_valid, rsp_err, rsp_tmo;
  logic [7:0] rsp_rdat;
  logic [5:0] mst_cmd;
  logic [7:0] mst_dat;
  logic       mst_ws;
  logic [1:0] mst_stat;
  logic [7:0] mst_rdat;

  int n_cmp = 0;
  int n_bad = 0;

  step_t      exp_q[$];
  logic [7:0] ref_ram [256];

  // Stub master controls
  bit hang = 1'b0;
  bit err_on_stop = 1'b0;
  int lat_max = 0;

  i2c_reg_seq #(.TMO_CYC(TMO), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdat(req_wdat),
    .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .mst_cmd(mst_cmd), .mst_dat(mst_dat), .mst_ws(mst_ws),
    .mst_stat(mst_stat), .mst_rdat(mst_rdat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stub master with one RAM device at DEV ----------------
  logic       m_bsy, m_err, m_pend, m_addr_ok, m_rd, m_first, m_ram_init;
  logic [5:0] m_cmd;
  logic [7:0] m_dat, m_ptr, m_rdat;
  int         m_left;
  logic [7:0] m_ram [256];
  logic       m_exec;

  assign mst_stat = {m_err, m_bsy};
  assign mst_rdat = m_rdat;
  assign m_exec   = !rst && !mst_ws && !hang &&
                    ((m_pend && m_left == 0) || (m_bsy && m_left == 1));

  // Busy timing: strobe seen, one cycle delay, then m_left busy cycles
  always @(posedge clk) begin
    if (rst) begin
      m_bsy  <= 1'b0;
      m_pend <= 1'b0;
      m_left <= 0;
    end else if (mst_ws) begin
      m_pend <= 1'b1;
      m_cmd  <= mst_cmd;
      m_dat  <= mst_dat;
      m_left <= (lat_max == 0 || (|(mst_cmd & C_CLRS))) ? 0 : int'($urandom_range(lat_max, 0));
    end else if (m_pend) begin
      m_pend <= 1'b0;
      if (hang || m_left != 0) m_bsy <= 1'b1;
    end else if (m_bsy && !hang) begin
      if (m_left <= 1) m_bsy <= 1'b0;
      else m_left <= m_left - 1;
    end
  end

  // Command execution against the device model
  always @(posedge clk) begin
    if (rst) begin
      m_err     <= 1'b0;
      m_addr_ok <= 1'b0;
      m_rd      <= 1'b0;
      m_first   <= 1'b0;
      m_rdat    <= 8'h00;
      m_ptr     <= 8'h00;
      if (m_ram_init !== 1'b1) begin
        for (int i = 0; i < 256; i++) m_ram[i] <= 8'(i * 7 + 3);
        m_ram_init <= 1'b1;
      end
    end else if (m_exec) begin
      if (|(m_cmd & C_CLRS)) begin
        m_err <= 1'b0;
      end else if (|(m_cmd & C_STRT)) begin
        m_addr_ok <= (m_dat[7:1] == DEV);
        m_rd      <= m_dat[0];
        m_first   <= 1'b1;
        if (m_dat[7:1] != DEV) m_err <= 1'b1;
      end else if (|(m_cmd & C_WRTE)) begin
        if (err_on_stop && (|(m_cmd & C_STOP))) begin
          m_err <= 1'b1;
        end else if (m_addr_ok && !m_rd) begin
          if (m_first) begin
            m_ptr   <= m_dat;
            m_first <= 1'b0;
          end else begin
            m_ram[m_ptr] <= m_dat;
          end
        end
      end else if (|(m_cmd & C_READ)) begin
        if (m_addr_ok && m_rd) m_rdat <= m_ram[m_ptr];
      end
    end
  end

  // ---------------- strobe / command monitor ----------------
  logic        ws_prev;
  logic [13:0] held;

  always @(negedge clk) begin
    if (rst) begin
      ws_prev <= 1'b0;
    end else begin
      if (mst_ws) begin
        step_t e;
        chk("ws_single", 32'(ws_prev), 32'd0);
        chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cmd", 32'(mst_cmd), 32'(e.cmd));
          if (e.care) chk("dat", 32'(mst_dat), 32'(e.dat));
        end
        held <= {mst_cmd, mst_dat};
      end else if (m_bsy && !req_ready) begin
        chk("hold_stable", 32'({mst_cmd, mst_dat}), 32'(held));
      end
      ws_prev <= mst_ws;
    end
  end

  task automatic push(input logic [5:0] c, input logic [7:0] d, input logic care);
    step_t s;
    s.cmd  = c;
    s.dat  = d;
    s.care = care;
    exp_q.push_back(s);
  endtask

  task automatic drive_accept(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [7:0] wd);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1;
    req_rnw   = rnw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdat  = wd;
    cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One request checked against the reference model; exp_lat 0 = don't check
  task automatic run_req(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input bit hold, input int exp_lat);
    bit         absent;
    bit         exp_err, exp_tmo;
    logic [7:0] exp_rd;
    int         cyc;
    absent  = (dev != DEV);
    exp_tmo = hang;
    exp_err = hang || absent || (!rnw && err_on_stop);
    exp_rd  = (rnw && !exp_err) ? ref_ram[rg] : 8'h00;
    push(C_STRT | C_WRTE, {dev, 1'b0}, 1'b1);
    if (!hang) begin
      if (absent) begin
        push(C_CLRS, 8'h00, 1'b0);
        push(C_STOP, 8'h00, 1'b0);
      end else if (!rnw) begin
        push(C_WRTE, rg, 1'b1);
        push(C_WRTE | C_STOP, wd, 1'b1);
        if (err_on_stop) begin
          push(C_CLRS, 8'h00, 1'b0);
          push(C_STOP, 8'h00, 1'b0);
        end
      end else begin
        push(C_WRTE, rg, 1'b1);
        push(C_STRT | C_WRTE, {dev, 1'b1}, 1'b1);
        push(C_READ | C_NACK, 8'h00, 1'b0);
        push(C_STOP, 8'h00, 1'b0);
      end
    end
    if (!rnw && !exp_err) ref_ram[rg] = wd;

    drive_accept(rnw, dev, rg, wd);
    if (!hold) req_valid = 1'b0;
    chk("ready_drop", 32'(req_ready), 32'd0);
    cyc = 1;
    while (!rsp_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    if (exp_lat > 0) chk("latency", 32'(cyc), 32'(exp_lat));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_tmo", 32'(rsp_tmo), 32'(exp_tmo));
    chk("rsp_rdat", 32'(rsp_rdat), 32'(exp_rd));
    chk("ready_in_resp", 32'(req_ready), 32'd0);
    chk("strobes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (!hold) begin
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("rsp_err_held", 32'(rsp_err), 32'(exp_err));
    end
  endtask

  // Reset pulse while the READ step is in flight
  task automatic reset_mid_read(input logic [7:0] rg);
    int cyc;
    int rsp_cnt;
    push(C_STRT | C_WRTE, {DEV, 1'b0}, 1'b1);
    push(C_WRTE, rg, 1'b1);
    push(C_STRT | C_WRTE, {DEV, 1'b1}, 1'b1);
    push(C_READ | C_NACK, 8'h00, 1'b0);
    drive_accept(1'b1, DEV, rg, 8'h00);
    req_valid = 1'b0;
    cyc = 0;
    while (!(mst_ws && mst_cmd == (C_READ | C_NACK)) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("rdata_reached", 32'(mst_ws && mst_cmd == (C_READ | C_NACK)), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_ws", 32'(mst_ws), 32'd0);
    chk("mid_rst_cmd", 32'(mst_cmd), 32'd0);
    chk("mid_rst_dat", 32'(mst_dat), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_err, rsp_tmo, rsp_rdat}), 32'd0);
    @(negedge clk);
    chk("mid_rst_ready_back", 32'(req_ready), 32'd1);
    rsp_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rnw   = 1'b0;
    req_dev   = '0;
    req_reg   = '0;
    req_wdat  = '0;
    for (int i = 0; i < 256; i++) ref_ram[i] = 8'(i * 7 + 3);

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_tmo, rsp_rdat}), 32'd0);
    chk("rst_mst", 32'({mst_ws, mst_cmd, mst_dat}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Zero-latency master: minimum latencies and directed cases
    lat_max = 0;
    run_req(1'b0, DEV, 8'h03, 8'h5C, 1'b0, 10);
    run_req(1'b1, DEV, 8'h03, 8'h00, 1'b0, 16);
    run_req(1'b1, 7'h20, 8'h03, 8'h00, 1'b0, 9);
    err_on_stop = 1'b1;
    run_req(1'b0, DEV, 8'h05, 8'hA7, 1'b0, 15);
    err_on_stop = 1'b0;
    run_req(1'b1, DEV, 8'h05, 8'h00, 1'b0, 16);

    // Master stuck busy: timeout, then no further strobes
    hang = 1'b1;
    run_req(1'b0, DEV, 8'h07, 8'h11, 1'b0, 3 + TMO);
    hang = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("ws_after_tmo", 32'(mst_ws), 32'd0);
    end

    // Back-to-back with req_valid held high
    lat_max = 2;
    for (int i = 0; i < 8; i++) run_req(1'b0, DEV, 8'(i), 8'((i + 1) * 17), 1'b1, 0);
    for (int i = 0; i < 8; i++) run_req(1'b1, DEV, 8'(i), 8'h00, 1'b1, 0);
    req_valid = 1'b0;

    reset_mid_read(8'h02);
    run_req(1'b1, DEV, 8'h02, 8'h00, 1'b0, 0);

    // Randomized traffic
    repeat (40) begin
      bit         rnw;
      logic [6:0] dev;
      rnw         = 1'($urandom_range(1, 0));
      dev         = ($urandom_range(5, 0) == 0) ? 7'h20 : DEV;
      err_on_stop = !rnw && ($urandom_range(7, 0) == 0);
      lat_max     = int'($urandom_range(4, 0));
      run_req(rnw, dev, 8'($urandom_range(15, 0)), 8'($urandom), 1'b0, 0);
      err_on_stop = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-access sequencer that sits directly upstream of `i2c_master` and drives its `cmd`/`dat`/`ws` interface while consuming `stat_out`/`dat_out`. It turns one request (7-bit device address, 8-bit register index, read or write) into the complete I2C command sequence with one-cycle write strobes, busy polling and error recovery. It returns a single response pulse carrying read data and error flags, so host logic never handles master commands directly.

## Interface
- `TMO_CYC`, default 1000000: maximum clock cycles one master step may stay busy before it is aborted.
- `TMO_W`, default 20: width of the timeout counter; must satisfy 2**TMO_W > TMO_CYC.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_rnw`  in  1  1 = register read, 0 = register write.
- `req_dev`  in  7  I2C device address.
- `req_reg`  in  8  register index.
- `req_wdat`  in  8  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdat`  out  8  read data; 0 for writes and errors.
- `rsp_err`  out  1  transaction failed (master `SB_ERR` or timeout).
- `rsp_tmo`  out  1  the failure was a timeout.
- `mst_cmd`  out  `C_SZ  command to master `cmd`.
- `mst_dat`  out  8  data to master `dat`.
- `mst_ws`  out  1  write strobe to master `ws`.
- `mst_stat`  in  `S_SZ  master `stat_out`.
- `mst_rdat`  in  8  master `dat_out`.

## Operation
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after reset. All other outputs are 0. The state machine is in IDLE.
- Acceptance: when `req_valid` && `req_ready` are both high, all `req_*` fields are latched and `req_ready` drops on the next cycle.
- Write sequence (three steps):
  - `C_STRT|C_WRTE` with {dev,0}
  - `C_WRTE` with reg
  - `C_WRTE|C_STOP` with wdat
- Read sequence (five steps):
  - `C_STRT|C_WRTE` with {dev,0}
  - `C_WRTE` with reg
  - `C_STRT|C_WRTE` with {dev,1}
  - `C_READ|C_NACK`
  - `C_STOP`
  - `mst_rdat` is captured when the READ step completes.
- Top FSM states: IDLE, ADDRW, REG, WDATA, ADDRR, RDATA, STOP, CLR, ABORTSTOP, RESP.
- Each step runs through three sub-states:
  - ISSUE: `mst_ws`=1 for exactly one cycle.
  - SETTLE: one cycle with no status check.
  - POLL: wait until `mst_stat[SB_BSY]`=0.
- Step outcome on leaving POLL:
  - If `mst_stat[SB_ERR]`=1, go to CLR.
  - Otherwise advance to the next step.
- CLR: issue `C_CLRS` (one strobe plus SETTLE), then ABORTSTOP.
- ABORTSTOP: issue `C_STOP`, then RESP with `rsp_err`=1, ignoring any error from this STOP.
- Timeout:
  - The counter clears on every ISSUE and increments in each POLL cycle with BSY=1.
  - When it reaches `TMO_CYC`, go to RESP with `rsp_err`=1 and `rsp_tmo`=1.
  - No further master commands are issued.
- RESP: `rsp_valid`=1 for one cycle, then IDLE. `req_ready` stays 0 during RESP.
- `mst_cmd`/`mst_dat` are held stable from ISSUE until the next ISSUE. They are 0 in IDLE.

## Timing
- Strobe: `mst_ws` rises on the clock edge that enters ISSUE and is low one cycle later. The block never issues two strobes in consecutive cycles.
- SETTLE masks the master's one-cycle delay before BSY asserts after a strobe.
- Minimum latency, write request, from acceptance to `rsp_valid` with a master that completes immediately: 3×3 + 1 = 10 cycles.
- Minimum latency, read request, same conditions: 5×3 + 1 = 16 cycles.
- Response flags and `rsp_rdat` are valid only while `rsp_valid`=1. They are held until the next accepted request.
- `req_valid` may be high in the RESP cycle; the request is accepted on the first IDLE cycle after RESP.
- Reset mid-sequence: on the next edge the block returns to IDLE, drops `mst_ws` to 0 and produces no response. The master shares `rst`, so no cleanup commands are sent.
- If SB_ERR is reported in the final write step (the one that includes STOP), the block still runs CLR and ABORTSTOP.

## Test plan
- Write reg 0x03 = 0x5C to the test RAM at 0x3A, then read reg 0x03 → write response has `rsp_err`=0; read response has `rsp_rdat`=0x5C, `rsp_err`=0; SCL/SDA show a repeated start before the read address byte.
- Read from an absent device at 0x20 → master NACK raises SB_ERR; the sequencer issues `C_CLRS` then `C_STOP`; `rsp_err`=1, `rsp_tmo`=0, `rsp_rdat`=0; the bus ends idle with SDA and SCL high.
- Stub master holding BSY=1 with `TMO_CYC`=50 → `rsp_valid` arrives 50 cycles after SETTLE with `rsp_err`=1 and `rsp_tmo`=1; `mst_ws` stays 0 afterwards.
- `req_valid` held high for eight back-to-back writes to regs 0..7 with data 0x11..0x88, then eight reads → every read returns the value written; `req_ready` never asserts during RESP.
- Assert `rst` for one cycle during the RDATA step → all outputs return to 0 and `req_ready` returns to 1; no `rsp_valid` occurs; the next request completes normally.
- Monitor across all tests → `mst_ws` is high for exactly one cycle per strobe, and `mst_cmd`/`mst_dat` never change while the master is busy.
